control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 42 ++++
 rtl/const_gen.sv | 30 +++
 rtl/control_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the control sequencer: FSM states, instruction classes, constant selects.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_DP_IMM  = 3'd0,
    CLS_DP_REG  = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_LDST    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } iclass_e;

  typedef enum logic [2:0] {
    K_ZERO  = 3'd0,
    K_IMM12 = 3'd1,
    K_OFF9  = 3'd2,
    K_BR26  = 3'd3,
    K_BR19  = 3'd4
  } ksel_e;

  // op is instruction bits [28:25]; the first matching pattern wins.
  function automatic iclass_e decode_class(input logic [3:0] op);
    iclass_e c;
    if (op[3:1] == 3'b100)              c = CLS_DP_IMM;
    else if (op[3:1] == 3'b101)         c = CLS_BRANCH;
    else if (op[2] && !op[0])           c = CLS_LDST;
    else if (op[2:0] == 3'b101)         c = CLS_DP_REG;
    else                                c = CLS_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/const_gen.sv
// Constant generator: extracts and extends an immediate field of the latched instruction.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows ir/k_sel every cycle.
module const_gen
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [2:0]        k_sel,
  output logic [DATA_W-1:0] k
);

  // Opcode bits above the widest immediate never feed a constant.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[DATA_W-1:26];

  // Select and extend the immediate field; unused selects give zero.
  always_comb begin
    k = '0;
    case (k_sel)
      K_IMM12: k = {{(DATA_W-12){1'b0}}, ir[21:10]};
      K_OFF9:  k = {{(DATA_W-9){ir[20]}}, ir[20:12]};
      K_BR26:  k = {{(DATA_W-26){ir[25]}}, ir[25:0]};
      K_BR19:  k = {{(DATA_W-19){ir[23]}}, ir[23:5]};
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control sequencer: fetch/decode/exec/mem/wb FSM driving datapath strobes.
// Latency: DP/branch 3 cycles, store 4, load 5 per instruction with zero memory wait.
// Backpressure: stalls in FETCH/MEM until mem_ready; traps after MEM_TIMEOUT wait cycles.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ir,
  input  logic              status,
  input  logic              mem_ready,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              reg_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              alu_src_k,
  output logic [2:0]        k_sel,
  output logic [DATA_W-1:0] k,
  output logic [2:0]        state,
  output logic              trap,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                trap_q, trap_d;
  iclass_e             cls;
  ksel_e               ksel;
  logic                wait_hit;
  logic                retire;

  assign cls      = decode_class(ir_q[28:25]);
  assign wait_hit = TIMEOUT_EN && (wait_q == WAIT_MAX);

  // Next-state and Moore strobes; FETCH ir_load/pc_inc additionally follow mem_ready.
  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_we    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    alu_src_k = 1'b0;
    ksel      = K_ZERO;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = (cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_DP_IMM: begin
            reg_we    = 1'b1;
            alu_src_k = 1'b1;
            ksel      = K_IMM12;
            state_d   = S_FETCH;
          end
          CLS_DP_REG: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_BRANCH: begin
            // IR[31] selects conditional (short offset, gated by ALU zero) vs unconditional.
            ksel    = ir_q[31] ? K_BR19 : K_BR26;
            pc_load = ir_q[31] ? status : 1'b1;
            state_d = S_FETCH;
          end
          CLS_LDST: begin
            alu_src_k = 1'b1;
            ksel      = K_OFF9;
            state_d   = S_MEM;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        alu_src_k = 1'b1;
        ksel      = K_OFF9;
        mem_rd    = ir_q[22];
        mem_wr    = !ir_q[22];
        if (mem_ready) begin
          state_d = ir_q[22] ? S_WB : S_FETCH;
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign k_sel = ksel;

  // An instruction retires whenever the FSM returns to FETCH from a working state.
  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
  assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // Wait counter restarts on any state change and saturates at the timeout value.
  assign wait_d = (state_d != state_q) ? '0 :
                  (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

  assign trap_d = trap_q || (state_d == S_TRAP);

  // State, instruction latch, counters and sticky trap flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= ir;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign state       = state_q;
  assign trap        = trap_q;
  assign instr_count = cnt_q;

  const_gen #(.DATA_W(DATA_W)) u_const_gen (
    .ir    (ir_q),
    .k_sel (k_sel),
    .k     (k)
  );

endmodule
